// File: rtl/serdesphy_reset_sequencer.sv
// PHY bring-up sequencer: PLL reset -> PLL lock -> TX enable -> CDR reset -> CDR lock -> READY,
// with lock timeouts, bounded retry and lock-loss recovery. Single 24 MHz reference domain.
module serdesphy_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 24,
    parameter int unsigned CDR_RST_CYCLES = 24,
    parameter int unsigned LOCK_TIMEOUT   = 2400,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk_ref_24m,
    input  logic       rst_n_24m,
    input  logic       phy_en_req,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    output logic       phy_en,
    output logic       pll_rst,
    output logic       cdr_rst,
    output logic       tx_en,
    output logic       rx_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPllRst  = 3'd1,
        StPllLock = 3'd2,
        StCdrRst  = 3'd3,
        StCdrLock = 3'd4,
        StReady   = 3'd5,
        StFault   = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CdrRstLast  = CNT_W'(CDR_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       MaxRetry    = 2'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       pll_sync_q, cdr_sync_q;
    logic             pll_lock_s, cdr_lock_s;
    logic             timing_state;
    logic             lock_timeout;

    assign pll_lock_s = pll_sync_q[1];
    assign cdr_lock_s = cdr_sync_q[1];
    assign lock_timeout = (timer_q == TimeoutLast);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (!phy_en_req) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StPllRst;
                    retry_d = '0;
                end
                StPllRst: begin
                    if (timer_q == PllRstLast) state_d = StPllLock;
                end
                StPllLock: begin
                    if (pll_lock_s) begin
                        state_d = StCdrRst;
                    end else if (lock_timeout) begin
                        if (retry_q < MaxRetry) begin
                            retry_d = retry_q + 2'd1;
                            state_d = StPllRst;
                        end else begin
                            state_d = StFault;
                        end
                    end
                end
                StCdrRst: begin
                    if (timer_q == CdrRstLast) state_d = StCdrLock;
                end
                StCdrLock: begin
                    if (cdr_lock_s) begin
                        state_d = StReady;
                        retry_d = '0;
                    end else if (lock_timeout) begin
                        if (retry_q < MaxRetry) begin
                            retry_d = retry_q + 2'd1;
                            state_d = StCdrRst;
                        end else begin
                            state_d = StFault;
                        end
                    end else if (!pll_lock_s) begin
                        // PLL dropped underneath us: restart from the PLL, not a retry
                        state_d = StPllRst;
                    end
                end
                StReady: begin
                    if (!pll_lock_s) begin
                        state_d = StPllRst;
                    end else if (!cdr_lock_s) begin
                        state_d = StCdrRst;
                    end
                end
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    assign timing_state = (state_q == StPllRst) || (state_q == StPllLock) ||
                          (state_q == StCdrRst) || (state_q == StCdrLock);

    always_comb begin
        timer_d = '0;
        if (state_d == state_q && timing_state) begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_ref_24m) begin
        if (!rst_n_24m) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            retry_q    <= '0;
            pll_sync_q <= '0;
            cdr_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            pll_sync_q <= {pll_sync_q[0], pll_lock};
            cdr_sync_q <= {cdr_sync_q[0], cdr_lock};
        end
    end

    always_comb begin
        phy_en  = 1'b0;
        pll_rst = 1'b0;
        cdr_rst = 1'b0;
        tx_en   = 1'b0;
        rx_en   = 1'b0;
        ready   = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            StIdle: begin
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
            end
            StPllRst: begin
                phy_en  = 1'b1;
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
            end
            StPllLock: begin
                phy_en  = 1'b1;
                cdr_rst = 1'b1;
            end
            StCdrRst: begin
                phy_en  = 1'b1;
                tx_en   = 1'b1;
                cdr_rst = 1'b1;
            end
            StCdrLock: begin
                phy_en = 1'b1;
                tx_en  = 1'b1;
            end
            StReady: begin
                phy_en = 1'b1;
                tx_en  = 1'b1;
                rx_en  = 1'b1;
                ready  = 1'b1;
            end
            StFault: begin
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
                fault   = 1'b1;
            end
            default: begin
                pll_rst = 1'b1;
                cdr_rst = 1'b1;
            end
        endcase
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule
